// File: rtl/ofs_fim_pcie_hdr_def.sv
// PCIe TLP header layouts, format/type codes, completion status codes and decode helpers
// shared by the FIM RX/TX TLP stages.
package ofs_fim_pcie_hdr_def;

    localparam logic [7:0] PCIE_FMTTYPE_MEM_READ32  = 8'h00;
    localparam logic [7:0] PCIE_FMTTYPE_MEM_READ64  = 8'h20;
    localparam logic [7:0] PCIE_FMTTYPE_MEM_WRITE32 = 8'h40;
    localparam logic [7:0] PCIE_FMTTYPE_MEM_WRITE64 = 8'h60;
    localparam logic [7:0] PCIE_FMTTYPE_CFG_RD0     = 8'h04;
    localparam logic [7:0] PCIE_FMTTYPE_CFG_WR0     = 8'h44;
    localparam logic [7:0] PCIE_FMTTYPE_CPL         = 8'h0A;
    localparam logic [7:0] PCIE_FMTTYPE_CPLD        = 8'h4A;

    localparam logic [2:0] PCIE_CPL_STATUS_SC = 3'b000;
    localparam logic [2:0] PCIE_CPL_STATUS_UR = 3'b001;
    localparam logic [2:0] PCIE_CPL_STATUS_CA = 3'b100;

    typedef struct packed {
        logic [7:0] fmttype;
        logic       rsvd0;
        logic [2:0] tc;
        logic [2:0] rsvd1;
        logic       th;
        logic       td;
        logic       ep;
        logic [1:0] attr;
        logic [1:0] rsvd2;
        logic [9:0] length;
    } t_tlp_hdr_dw0;

    typedef struct packed {
        t_tlp_hdr_dw0 dw0;
        logic [15:0]  requester_id;
        logic [7:0]   tag;
        logic [3:0]   last_be;
        logic [3:0]   first_be;
        logic [31:0]  addr;
        logic [31:0]  lsb_addr;
    } t_tlp_mem_req_hdr;

    typedef struct packed {
        t_tlp_hdr_dw0 dw0;
        logic [15:0]  completer_id;
        logic [2:0]   status;
        logic         bcm;
        logic [11:0]  byte_count;
        logic [15:0]  requester_id;
        logic [7:0]   tag;
        logic         rsvd0;
        logic [6:0]   lower_addr;
        logic [31:0]  rsvd1;
    } t_tlp_cpl_hdr;

    function automatic logic func_is_addr64(input logic [7:0] fmttype);
        return fmttype[5];
    endfunction

    function automatic logic func_is_mem_rd(input logic [7:0] fmttype);
        return (fmttype == PCIE_FMTTYPE_MEM_READ32) || (fmttype == PCIE_FMTTYPE_MEM_READ64);
    endfunction

    function automatic logic func_is_mem_wr(input logic [7:0] fmttype);
        return (fmttype == PCIE_FMTTYPE_MEM_WRITE32) || (fmttype == PCIE_FMTTYPE_MEM_WRITE64);
    endfunction

    function automatic logic func_is_mem_req(input logic [7:0] fmttype);
        return func_is_mem_rd(fmttype) || func_is_mem_wr(fmttype);
    endfunction

    function automatic logic func_is_msg(input logic [7:0] fmttype);
        return (fmttype[7:3] == 5'b00110) || (fmttype[7:3] == 5'b01110);
    endfunction

    function automatic logic func_is_completion(input logic [7:0] fmttype);
        return fmttype[4:0] == 5'b01010;
    endfunction

endpackage

// File: rtl/ofs_fim_mmio_tlp_cpl_gen.sv
// Host MMIO terminator: MWr/MRd TLPs -> registered CSR strobes (T+1); MRd answered with CplD, CSR reads bounded by timeout.
// One request in flight: rx_ready only in IDLE; completion held on tx until tx_ready.
module ofs_fim_mmio_tlp_cpl_gen
    import ofs_fim_pcie_hdr_def::*;
#(
    parameter logic [15:0] COMPLETER_ID   = 16'h0000,
    parameter int          CSR_ADDR_W     = 20,
    parameter int          TIMEOUT_CYCLES = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic [127:0]          rx_hdr,
    input  logic [63:0]           rx_data,

    output logic                  csr_wr,
    output logic                  csr_rd,
    output logic [CSR_ADDR_W-1:0] csr_addr,
    output logic [63:0]           csr_wdata,
    output logic [7:0]            csr_wbe,
    input  logic                  csr_rdata_valid,
    input  logic [63:0]           csr_rdata,

    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [127:0]          tx_hdr,
    output logic [63:0]           tx_data,

    output logic                  err_unsup,
    output logic                  err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WR      = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;
    localparam logic [1:0] ST_CPL     = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  ready_en_q;
    logic                  csr_wr_q, csr_wr_d;
    logic                  csr_rd_q, csr_rd_d;
    logic [CSR_ADDR_W-1:0] csr_addr_q, csr_addr_d;
    logic [63:0]           csr_wdata_q, csr_wdata_d;
    logic [7:0]            csr_wbe_q, csr_wbe_d;
    logic                  tx_valid_q, tx_valid_d;
    t_tlp_cpl_hdr          tx_hdr_q, tx_hdr_d;
    logic [63:0]           tx_data_q, tx_data_d;
    logic                  err_unsup_q, err_unsup_d;
    logic                  err_timeout_q, err_timeout_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  a2_q, a2_d;
    logic                  len2_q, len2_d;

    t_tlp_mem_req_hdr      req;
    logic [31:0]           req_addr;
    logic [CSR_ADDR_W-1:0] a;
    logic                  len1, len2, legal, accept;
    logic                  timeout_hit;
    logic [63:0]           rdata_sel;
    t_tlp_cpl_hdr          cpld_hdr, ur_hdr;
    logic                  unused_bits;

    assign req      = t_tlp_mem_req_hdr'(rx_hdr);
    assign req_addr = func_is_addr64(req.dw0.fmttype) ? req.lsb_addr : req.addr;
    assign a        = req_addr[CSR_ADDR_W-1:0];
    assign len1     = (req.dw0.length == 10'd1);
    assign len2     = (req.dw0.length == 10'd2);
    assign legal    = func_is_mem_req(req.dw0.fmttype) && (len1 || (len2 && !a[2]));
    assign accept   = rx_valid && rx_ready;

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rdata_sel   = csr_rdata_valid ? csr_rdata : '1;

    always_comb begin
        cpld_hdr                  = '0;
        cpld_hdr.dw0.fmttype      = PCIE_FMTTYPE_CPLD;
        cpld_hdr.dw0.tc           = req.dw0.tc;
        cpld_hdr.dw0.attr         = req.dw0.attr;
        cpld_hdr.dw0.length       = req.dw0.length;
        cpld_hdr.completer_id     = COMPLETER_ID;
        cpld_hdr.status           = PCIE_CPL_STATUS_SC;
        cpld_hdr.byte_count       = {req.dw0.length, 2'b00};
        cpld_hdr.requester_id     = req.requester_id;
        cpld_hdr.tag              = req.tag;
        cpld_hdr.lower_addr       = {a[6:2], 2'b00};

        // UR completion carries no data: length 0 but a nominal 4-byte count.
        ur_hdr                    = cpld_hdr;
        ur_hdr.dw0.fmttype        = PCIE_FMTTYPE_CPL;
        ur_hdr.dw0.length         = 10'd0;
        ur_hdr.status             = PCIE_CPL_STATUS_UR;
        ur_hdr.byte_count         = 12'd4;
    end

    always_comb begin
        state_d       = state_q;
        csr_wr_d      = 1'b0;
        csr_rd_d      = 1'b0;
        csr_addr_d    = csr_addr_q;
        csr_wdata_d   = csr_wdata_q;
        csr_wbe_d     = csr_wbe_q;
        tx_valid_d    = tx_valid_q;
        tx_hdr_d      = tx_hdr_q;
        tx_data_d     = tx_data_q;
        err_unsup_d   = 1'b0;
        err_timeout_d = 1'b0;
        cnt_d         = cnt_q;
        a2_d          = a2_q;
        len2_d        = len2_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (legal && func_is_mem_wr(req.dw0.fmttype)) begin
                        state_d    = ST_WR;
                        csr_wr_d   = 1'b1;
                        csr_addr_d = {a[CSR_ADDR_W-1:3], 3'b000};
                        if (len2) begin
                            csr_wdata_d = rx_data;
                            csr_wbe_d   = {req.last_be, req.first_be};
                        end else begin
                            csr_wdata_d = a[2] ? {rx_data[31:0], 32'h0} : {32'h0, rx_data[31:0]};
                            csr_wbe_d   = a[2] ? {req.first_be, 4'h0} : {4'h0, req.first_be};
                        end
                    end else if (legal) begin
                        state_d    = ST_RD_WAIT;
                        csr_rd_d   = 1'b1;
                        csr_addr_d = {a[CSR_ADDR_W-1:3], 3'b000};
                        cnt_d      = '0;
                        a2_d       = a[2];
                        len2_d     = len2;
                        tx_hdr_d   = cpld_hdr;
                    end else if (func_is_mem_rd(req.dw0.fmttype)) begin
                        state_d     = ST_CPL;
                        tx_valid_d  = 1'b1;
                        tx_hdr_d    = ur_hdr;
                        tx_data_d   = '0;
                        err_unsup_d = 1'b1;
                    end else begin
                        err_unsup_d = 1'b1;
                    end
                end
            end
            ST_WR: begin
                state_d = ST_IDLE;
            end
            ST_RD_WAIT: begin
                if (csr_rdata_valid || timeout_hit) begin
                    state_d       = ST_CPL;
                    tx_valid_d    = 1'b1;
                    err_timeout_d = !csr_rdata_valid;
                    tx_data_d     = len2_q ? rdata_sel
                                           : {32'h0, a2_q ? rdata_sel[63:32] : rdata_sel[31:0]};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (tx_ready) begin
                    state_d    = ST_IDLE;
                    tx_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ready_en_q    <= 1'b0;
            csr_wr_q      <= 1'b0;
            csr_rd_q      <= 1'b0;
            csr_addr_q    <= '0;
            csr_wdata_q   <= '0;
            csr_wbe_q     <= '0;
            tx_valid_q    <= 1'b0;
            tx_hdr_q      <= '0;
            tx_data_q     <= '0;
            err_unsup_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            cnt_q         <= '0;
            a2_q          <= 1'b0;
            len2_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ready_en_q    <= 1'b1;
            csr_wr_q      <= csr_wr_d;
            csr_rd_q      <= csr_rd_d;
            csr_addr_q    <= csr_addr_d;
            csr_wdata_q   <= csr_wdata_d;
            csr_wbe_q     <= csr_wbe_d;
            tx_valid_q    <= tx_valid_d;
            tx_hdr_q      <= tx_hdr_d;
            tx_data_q     <= tx_data_d;
            err_unsup_q   <= err_unsup_d;
            err_timeout_q <= err_timeout_d;
            cnt_q         <= cnt_d;
            a2_q          <= a2_d;
            len2_q        <= len2_d;
        end
    end

    // ready_en_q keeps rx_ready low while in reset and until the first clock after release.
    assign rx_ready    = ready_en_q && (state_q == ST_IDLE);
    assign csr_wr      = csr_wr_q;
    assign csr_rd      = csr_rd_q;
    assign csr_addr    = csr_addr_q;
    assign csr_wdata   = csr_wdata_q;
    assign csr_wbe     = csr_wbe_q;
    assign tx_valid    = tx_valid_q;
    assign tx_hdr      = tx_hdr_q;
    assign tx_data     = tx_data_q;
    assign err_unsup   = err_unsup_q;
    assign err_timeout = err_timeout_q;

    assign unused_bits = ^{rx_hdr, req_addr};

endmodule

// File: tb/tb_ofs_fim_mmio_tlp_cpl_gen.sv
// Directed bench for ofs_fim_mmio_tlp_cpl_gen: MWr/MRd paths, timeout, UR/drop and mid-read reset.
module tb_ofs_fim_mmio_tlp_cpl_gen;
    import ofs_fim_pcie_hdr_def::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rx_valid, rx_ready;
    logic [127:0] rx_hdr;
    logic [63:0]  rx_data;
    logic         csr_wr, csr_rd;
    logic [19:0]  csr_addr;
    logic [63:0]  csr_wdata;
    logic [7:0]   csr_wbe;
    logic         csr_rdata_valid;
    logic [63:0]  csr_rdata;
    logic         tx_valid, tx_ready;
    logic [127:0] tx_hdr;
    logic [63:0]  tx_data;
    logic         err_unsup, err_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    ofs_fim_mmio_tlp_cpl_gen dut (
        .clk(clk), .rst_n(rst_n),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_hdr(rx_hdr), .rx_data(rx_data),
        .csr_wr(csr_wr), .csr_rd(csr_rd), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_wbe(csr_wbe), .csr_rdata_valid(csr_rdata_valid), .csr_rdata(csr_rdata),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_hdr(tx_hdr), .tx_data(tx_data),
        .err_unsup(err_unsup), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk_req(input logic [7:0] ft, input logic [9:0] len,
                                            input logic [15:0] rid, input logic [7:0] tag,
                                            input logic [3:0] lbe, input logic [3:0] fbe,
                                            input logic [31:0] addr, input logic [31:0] lsb);
        t_tlp_mem_req_hdr h;
        h = '0;
        h.dw0.fmttype = ft;  h.dw0.length = len;
        h.requester_id = rid; h.tag = tag;
        h.last_be = lbe; h.first_be = fbe;
        h.addr = addr; h.lsb_addr = lsb;
        return h;
    endfunction

    function automatic logic [127:0] mk_cpl(input logic [7:0] ft, input logic [9:0] len,
                                            input logic [2:0] st, input logic [11:0] bc,
                                            input logic [15:0] rid, input logic [7:0] tag,
                                            input logic [6:0] la);
        t_tlp_cpl_hdr h;
        h = '0;
        h.dw0.fmttype = ft; h.dw0.length = len;
        h.completer_id = 16'h0000; h.status = st; h.byte_count = bc;
        h.requester_id = rid; h.tag = tag; h.lower_addr = la;
        return h;
    endfunction

    // Presents one flit for a single edge; returns in cycle T+1.
    task automatic send(input logic [127:0] hdr, input logic [63:0] data);
        rx_valid = 1'b1;
        rx_hdr   = hdr;
        rx_data  = data;
        tick();
        rx_valid = 1'b0;
        rx_hdr   = '0;
        rx_data  = '0;
    endtask

    initial begin
        logic [127:0] exp_hdr;
        int k;
        int rd_extra;

        rst_n = 1'b0; rx_valid = 1'b0; rx_hdr = '0; rx_data = '0;
        csr_rdata_valid = 1'b0; csr_rdata = '0; tx_ready = 1'b0;

        #3;
        chk("rst_ctl", {rx_ready, csr_wr, csr_rd, tx_valid, err_unsup, err_timeout}, 6'b0);
        chk("rst_csr", {csr_addr, csr_wdata, csr_wbe}, '0);
        chk("rst_tx", {tx_hdr}, '0);
        chk("rst_txd", tx_data, '0);
        #20 rst_n = 1'b1;
        #1 chk("rdy_before_clk", rx_ready, 1'b0);
        tick();
        chk("rdy_after_clk", rx_ready, 1'b1);

        // MWr32 len1 at 0x1004: upper lane; lsb_addr ignored for 32-bit requests
        send(mk_req(PCIE_FMTTYPE_MEM_WRITE32, 10'd1, 16'h0, 8'h0, 4'h0, 4'hF, 32'h1004, 32'hFFFF_FFF0),
             64'h0000_0000_DEAD_BEEF);
        chk("mwr32_wr", {csr_wr, csr_rd, rx_ready}, 3'b100);
        chk("mwr32_addr", csr_addr, 20'h01000);
        chk("mwr32_wdata", csr_wdata, 64'hDEADBEEF_00000000);
        chk("mwr32_wbe", csr_wbe, 8'hF0);
        tick();
        chk("mwr32_t2", {csr_wr, rx_ready}, 2'b01);

        // MWr64 len2 via lsb_addr
        send(mk_req(PCIE_FMTTYPE_MEM_WRITE64, 10'd2, 16'h0, 8'h0, 4'hF, 4'hF, 32'h0, 32'h2000),
             64'h0123456789ABCDEF);
        chk("mwr64_wr", csr_wr, 1'b1);
        chk("mwr64_addr", csr_addr, 20'h02000);
        chk("mwr64_wdata", csr_wdata, 64'h0123456789ABCDEF);
        chk("mwr64_wbe", csr_wbe, 8'hFF);
        chk("mwr64_rdy_t1", rx_ready, 1'b0);
        tick();
        chk("mwr64_rdy_t2", {csr_wr, rx_ready}, 2'b01);

        // len2 with A[2]=1 is illegal: dropped
        send(mk_req(PCIE_FMTTYPE_MEM_WRITE32, 10'd2, 16'h0, 8'h0, 4'hF, 4'hF, 32'h4, 32'h0),
             64'h1111_2222_3333_4444);
        chk("mwr_bad_len2", {csr_wr, err_unsup, tx_valid, rx_ready}, 4'b0101);
        tick();
        chk("mwr_bad_pulse", err_unsup, 1'b0);

        // MRd32 len1 at 0x8
        send(mk_req(PCIE_FMTTYPE_MEM_READ32, 10'd1, 16'h0100, 8'h15, 4'h0, 4'hF, 32'h8, 32'h0), '0);
        chk("mrd32_rd", {csr_rd, csr_wr, rx_ready}, 3'b100);
        chk("mrd32_addr", csr_addr, 20'h00008);
        tick();
        chk("mrd32_rd_once", csr_rd, 1'b0);
        tick();
        chk("mrd32_no_tx", tx_valid, 1'b0);
        csr_rdata_valid = 1'b1; csr_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        tick();
        csr_rdata_valid = 1'b0; csr_rdata = '0;
        exp_hdr = mk_cpl(PCIE_FMTTYPE_CPLD, 10'd1, 3'b000, 12'd4, 16'h0100, 8'h15, 7'h08);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("mrd32_hold_v%0d", i), tx_valid, 1'b1);
            chk($sformatf("mrd32_hold_h%0d", i), tx_hdr, exp_hdr);
            chk($sformatf("mrd32_hold_d%0d", i), tx_data, 64'h0000_0000_CCCC_DDDD);
            tick();
        end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        chk("mrd32_done", {tx_valid, rx_ready}, 2'b01);

        // MRd64 len2, CSR never answers
        send(mk_req(PCIE_FMTTYPE_MEM_READ64, 10'd2, 16'h0300, 8'h22, 4'hF, 4'hF, 32'h1, 32'h10), '0);
        chk("mrd64_rd", csr_rd, 1'b1);
        chk("mrd64_addr", csr_addr, 20'h00010);
        k = 1;
        rd_extra = 0;
        tick();
        k = 2;
        while (!err_timeout && k < 700) begin
            if (csr_rd || tx_valid) rd_extra++;
            tick();
            k++;
        end
        chk("to_cycle", k, 513);
        chk("to_no_extra", rd_extra, 0);
        chk("to_valid", tx_valid, 1'b1);
        chk("to_data", tx_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("to_hdr", tx_hdr, mk_cpl(PCIE_FMTTYPE_CPLD, 10'd2, 3'b000, 12'd8, 16'h0300, 8'h22, 7'h10));
        csr_rdata_valid = 1'b1; csr_rdata = 64'h1234;
        tick();
        csr_rdata_valid = 1'b0;
        chk("to_pulse", err_timeout, 1'b0);
        chk("late_ignored", tx_data, 64'hFFFF_FFFF_FFFF_FFFF);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        csr_rdata_valid = 1'b1;
        tick();
        csr_rdata_valid = 1'b0;
        chk("late_idle", {tx_valid, rx_ready}, 2'b01);

        // MRd len4: UR completion at T+1, no CSR access
        send(mk_req(PCIE_FMTTYPE_MEM_READ32, 10'd4, 16'h0400, 8'h33, 4'hF, 4'hF, 32'h40, 32'h0), '0);
        chk("ur_ctl", {tx_valid, err_unsup, csr_rd, rx_ready}, 4'b1100);
        chk("ur_hdr", tx_hdr, mk_cpl(PCIE_FMTTYPE_CPL, 10'd0, 3'b001, 12'd4, 16'h0400, 8'h33, 7'h40));
        chk("ur_data", tx_data, '0);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        chk("ur_done", {tx_valid, err_unsup, csr_rd, rx_ready}, 4'b0001);

        // MsgD: consumed and dropped
        send(mk_req(8'h74, 10'd1, 16'h0, 8'h0, 4'h0, 4'hF, 32'h0, 32'h0), 64'h5);
        chk("msg_drop", {err_unsup, tx_valid, csr_wr, csr_rd, rx_ready}, 5'b10001);
        tick();
        chk("msg_after", {err_unsup, tx_valid}, 2'b00);

        // Reset while in RD_WAIT
        send(mk_req(PCIE_FMTTYPE_MEM_READ32, 10'd1, 16'h0500, 8'h44, 4'h0, 4'hF, 32'hC, 32'h0), '0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", {rx_ready, csr_wr, csr_rd, tx_valid, err_unsup, err_timeout}, 6'b0);
        chk("mid_rst_csr", {csr_addr, csr_wdata, csr_wbe}, '0);
        chk("mid_rst_tx", tx_hdr, '0);
        #3 rst_n = 1'b1;
        csr_rdata_valid = 1'b1; csr_rdata = 64'h9999;
        tick();
        csr_rdata_valid = 1'b0;
        chk("post_rst_quiet", {rx_ready, csr_wr, csr_rd, tx_valid}, 4'b1000);

        send(mk_req(PCIE_FMTTYPE_MEM_READ32, 10'd1, 16'h0200, 8'h5A, 4'h0, 4'hF, 32'h4, 32'h0), '0);
        chk("post_rst_rd", csr_rd, 1'b1);
        chk("post_rst_addr", csr_addr, 20'h00000);
        tick();
        csr_rdata_valid = 1'b1; csr_rdata = 64'h1111_2222_3333_4444;
        tick();
        csr_rdata_valid = 1'b0;
        chk("post_rst_valid", tx_valid, 1'b1);
        chk("post_rst_data", tx_data, 64'h0000_0000_1111_2222);
        chk("post_rst_hdr", tx_hdr, mk_cpl(PCIE_FMTTYPE_CPLD, 10'd1, 3'b000, 12'd4, 16'h0200, 8'h5A, 7'h04));
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        chk("post_rst_done", {tx_valid, rx_ready}, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
